d16_uart: RTL and testbench

D16_UART -- requirements
Module: d16_uart

---
 rtl/d16_uart.sv | 278 +++++++++++++++++++++++++++
 tb/tb_d16_uart.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/d16_uart.sv
// Memory-mapped UART for the d16 CPU bus: 8-entry TX FIFO, single-byte RX holding register,
// status/control registers and a registered interrupt request.
module d16_uart #(
  parameter int CLKDIV = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_int,
  input  logic        i_rx,
  output logic        o_tx
);

  localparam logic [15:0] DIV_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                            RX_BRK = 3'd4} rx_state_e;

  logic acc_s, wr_data_s, rd_data_s, wr_stat_s, wr_ctrl_s, push_s, pop_s;
  logic [7:0] fifo_q [8];
  logic [2:0] wptr_q, rptr_q;
  logic [3:0] cnt_q, cnt_d;
  tx_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d, tx_tick_s, tx_busy_s, tx_empty_s;
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e  rx_state_q, rx_state_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_byte_q;
  logic       rx_done_s, rx_ferr_s, rx_valid_q, rx_overrun_q, rx_ferr_q;
  logic       rx_ie_q, tx_ie_q, int_q;
  logic       unused_s;

  assign acc_s      = i_cs & i_wb_cyc;
  assign wr_data_s  = acc_s & i_wb_we & (i_wb_addr == 2'd0);
  assign rd_data_s  = acc_s & ~i_wb_we & (i_wb_addr == 2'd0);
  assign wr_stat_s  = acc_s & i_wb_we & (i_wb_addr == 2'd1);
  assign wr_ctrl_s  = acc_s & i_wb_we & (i_wb_addr == 2'd2);
  assign push_s     = wr_data_s & ((cnt_q != 4'd8) | pop_s);
  assign tx_busy_s  = (tx_state_q != TX_IDLE);
  assign tx_empty_s = (cnt_q == 4'd0);
  assign tx_tick_s  = (tx_div_q == DIV_LAST);
  assign unused_s   = ^i_wb_dat[15:8];
  assign o_tx       = tx_q;
  assign o_int      = int_q;

  // Read mux; reads have no bus latency so this stays combinational
  always_comb begin
    o_wb_dat = 16'd0;
    if (acc_s & ~i_wb_we) begin
      case (i_wb_addr)
        2'd0:    o_wb_dat = {7'd0, rx_valid_q, rx_byte_q};
        2'd1:    o_wb_dat = {4'd0, cnt_q, 2'd0, rx_ferr_q, tx_busy_s, rx_overrun_q, rx_valid_q,
                             (cnt_q == 4'd8), tx_empty_s};
        2'd2:    o_wb_dat = {14'd0, tx_ie_q, rx_ie_q};
        default: o_wb_dat = 16'd0;
      endcase
    end else begin
      o_wb_dat = 16'd0;
    end
  end

  // FIFO storage is data-only and needs no reset
  always_ff @(posedge i_clk) begin
    if (push_s) fifo_q[wptr_q] <= i_wb_dat[7:0];
  end

  // FIFO occupancy after simultaneous push/pop
  always_comb begin
    cnt_d = cnt_q + {3'd0, push_s} - {3'd0, pop_s};
  end

  // FIFO pointers and count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q <= 3'd0;
      rptr_q <= 3'd0;
      cnt_q  <= 4'd0;
    end else begin
      wptr_q <= wptr_q + {2'd0, push_s};
      rptr_q <= rptr_q + {2'd0, pop_s};
      cnt_q  <= cnt_d;
    end
  end

  // TX state register; o_tx is registered from the next-state outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state; leaving STOP with data queued goes straight to START
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop_s      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (cnt_q != 4'd0) begin
          tx_state_d = TX_START;
          tx_div_d   = 16'd0;
          tx_shift_d = fifo_q[rptr_q];
          pop_s      = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_tick_s) begin
          tx_state_d = TX_DATA;
          tx_div_d   = 16'd0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_div_d = tx_div_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_tick_s) begin
          tx_div_d   = 16'd0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_state_d = TX_DATA;
        end else begin
          tx_div_d = tx_div_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_tick_s) begin
          tx_div_d = 16'd0;
          if (cnt_q != 4'd0) begin
            tx_state_d = TX_START;
            tx_shift_d = fifo_q[rptr_q];
            pop_s      = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_div_d = tx_div_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX line value for the upcoming cycle
  always_comb begin
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // RX synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_div_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_s1_q    <= i_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state; BRK holds off after a framing error until the line is high again
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_div_d = 16'd0;
        if (rx_prev_q & ~rx_s2_q) rx_state_d = RX_START;
        else                      rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (rx_div_q == HALF_LAST) begin
          rx_div_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_div_q == DIV_LAST) begin
          rx_div_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_div_q == DIV_LAST) rx_state_d = rx_s2_q ? RX_IDLE : RX_BRK;
        else                      rx_state_d = RX_STOP;
      end
      RX_BRK: begin
        rx_div_d = 16'd0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
        else         rx_state_d = RX_BRK;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX frame completion events at the stop-bit sample
  always_comb begin
    rx_done_s = (rx_state_q == RX_STOP) & (rx_div_q == DIV_LAST) & rx_s2_q;
    rx_ferr_s = (rx_state_q == RX_STOP) & (rx_div_q == DIV_LAST) & ~rx_s2_q;
  end

  // Status, control and interrupt registers; setting events win over clears
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= 8'd0;
      rx_overrun_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_ie_q      <= 1'b0;
      tx_ie_q      <= 1'b0;
      int_q        <= 1'b0;
    end else begin
      if (rx_done_s & (~rx_valid_q | rd_data_s)) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= rx_shift_q;
      end else if (rd_data_s) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_done_s & rx_valid_q & ~rd_data_s) rx_overrun_q <= 1'b1;
      else if (wr_stat_s & i_wb_dat[3])        rx_overrun_q <= 1'b0;
      if (rx_ferr_s)                      rx_ferr_q <= 1'b1;
      else if (wr_stat_s & i_wb_dat[5])   rx_ferr_q <= 1'b0;
      if (wr_ctrl_s) begin
        rx_ie_q <= i_wb_dat[0];
        tx_ie_q <= i_wb_dat[1];
      end
      int_q <= (rx_ie_q & rx_valid_q) | (tx_ie_q & tx_empty_s & ~tx_busy_s);
    end
  end

endmodule

// File: tb/tb_d16_uart.sv
// Self-checking bench for d16_uart: bus register checks, TX frame monitor with a byte
// scoreboard, RX frame driver with a read-side scoreboard, interrupt and reset behaviour.
module tb_d16_uart;
  localparam int CLKDIV = 4;
  localparam int FRAME  = 10 * CLKDIV;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_cs = 1'b0, i_wb_cyc = 1'b0, i_wb_we = 1'b0;
  logic [1:0]  i_wb_addr = 2'd0;
  logic [15:0] i_wb_dat = 16'd0;
  logic [15:0] o_wb_dat;
  logic        o_int, o_tx;
  logic        i_rx = 1'b1;

  int          n_tests = 0, n_fail = 0;
  logic [7:0]  tx_exp_q [$];
  logic [15:0] rx_exp_q [$];
  logic        rx_full_m = 1'b0;
  logic [7:0]  rx_last_m = 8'h00;
  logic        mon_en = 1'b1;

  d16_uart #(.CLKDIV(CLKDIV)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(i_cs), .i_wb_cyc(i_wb_cyc), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat), .o_int(o_int),
    .i_rx(i_rx), .o_tx(o_tx)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge i_clk);
    i_cs = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_dat = d;
    @(posedge i_clk);
    #1 i_cs = 1'b0; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge i_clk);
    i_cs = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    #1 d = o_wb_dat;
    @(posedge i_clk);
    #1 i_cs = 1'b0; i_wb_cyc = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check_eq(tag, {16'd0, d}, {16'd0, exp});
  endtask

  // Expected DATA read value from the RX scoreboard; the read clears the model's valid flag
  task automatic rx_model_read(output logic [15:0] e);
    if (rx_full_m && rx_exp_q.size() != 0) begin
      e = rx_exp_q.pop_front();
      rx_full_m = 1'b0;
    end else begin
      e = {8'h00, rx_last_m};
    end
  endtask

  task automatic data_read_check(input string tag);
    logic [15:0] d, e;
    bus_read(2'd0, d);
    rx_model_read(e);
    check_eq(tag, {16'd0, d}, {16'd0, e});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge i_clk);
    for (int k = 0; k < 10; k++) begin
      i_rx = bits[k];
      repeat (CLKDIV) @(negedge i_clk);
    end
    i_rx = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b);
    send_rx(b, 1'b1);
    if (!rx_full_m) begin
      rx_exp_q.push_back({8'h01, b});
      rx_full_m = 1'b1;
      rx_last_m = b;
    end
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 20 * FRAME && tx_exp_q.size() != 0; i++) @(negedge i_clk);
    check_eq("tx_drain", tx_exp_q.size(), 0);
    repeat (FRAME + 4) @(negedge i_clk);
  endtask

  // TX monitor: checks every cycle of each frame against the next expected byte
  initial begin : tx_mon
    logic [7:0] exp_b, got_b;
    logic       e;
    int         errs, b;
    bit         more, aborted;
    forever begin
      @(negedge i_clk);
      if (mon_en && (o_tx === 1'b0)) begin
        more = 1'b1;
        while (more) begin
          more = 1'b0; aborted = 1'b0; errs = 0; got_b = 8'h00;
          if (tx_exp_q.size() == 0) begin
            check_eq("tx_unexpected_frame", 32'd1, 32'd0);
            exp_b = 8'h00;
          end else begin
            exp_b = tx_exp_q.pop_front();
          end
          for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge i_clk);
            if (!mon_en) begin
              aborted = 1'b1;
              break;
            end
            b = c / CLKDIV;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = exp_b[b-1];
            if (o_tx !== e) errs++;
            if (b >= 1 && b <= 8 && (c % CLKDIV) == CLKDIV / 2) got_b[b-1] = o_tx;
          end
          if (!aborted) begin
            check_eq("tx_frame_bits", errs, 0);
            check_eq("tx_byte", {24'd0, got_b}, {24'd0, exp_b});
            if (tx_exp_q.size() != 0) begin
              @(negedge i_clk);
              if (mon_en) begin
                check_eq("tx_no_gap", {31'd0, o_tx}, 32'd0);
                more = (o_tx === 1'b0);
              end
            end
          end
        end
      end
    end
  end

  initial begin : main
    logic [15:0] d, e;
    logic        found;

    // Reset state
    repeat (3) @(negedge i_clk);
    check_eq("reset_tx", {31'd0, o_tx}, 32'd1);
    check_eq("reset_int", {31'd0, o_int}, 32'd0);
    i_reset = 1'b0;
    read_check("reset_status", 2'd1, 16'h0001);
    read_check("reset_data", 2'd0, 16'h0000);
    read_check("reset_ctrl", 2'd2, 16'h0000);
    bus_write(2'd3, 16'hFFFF);
    read_check("addr3_read", 2'd3, 16'h0000);
    read_check("ctrl_after_addr3", 2'd2, 16'h0000);

    // Single byte, LSB first
    tx_exp_q.push_back(8'h55);
    bus_write(2'd0, 16'h0155);
    wait_tx_drain();
    read_check("status_after_tx", 2'd1, 16'h0001);

    // Nine back-to-back writes: one popped at once, eight queued, none dropped
    @(negedge i_clk);
    for (int i = 0; i < 9; i++) begin
      i_cs = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_addr = 2'd0;
      i_wb_dat = {8'h00, 8'h30 + 8'(i * 17)};
      tx_exp_q.push_back(8'h30 + 8'(i * 17));
      @(negedge i_clk);
    end
    i_wb_we = 1'b0; i_wb_addr = 2'd1;
    #1 check_eq("status_fifo_full", {16'd0, o_wb_dat}, 32'h0812);
    i_cs = 1'b0; i_wb_cyc = 1'b0;
    wait_tx_drain();
    read_check("status_after_burst", 2'd1, 16'h0001);

    // Receive 0xA5, read twice
    rx_frame(8'hA5);
    repeat (4) @(negedge i_clk);
    read_check("status_rx_valid", 2'd1, 16'h0005);
    data_read_check("rx_a5_first");
    data_read_check("rx_a5_second");

    // Overrun: second byte discarded
    rx_frame(8'h11);
    repeat (2) @(negedge i_clk);
    rx_frame(8'h22);
    repeat (4) @(negedge i_clk);
    data_read_check("rx_overrun_data");
    read_check("status_overrun", 2'd1, 16'h0009);
    bus_write(2'd1, 16'h0008);
    read_check("status_overrun_clr", 2'd1, 16'h0001);

    // Framing error: stop bit low
    send_rx(8'h00, 1'b0);
    repeat (4) @(negedge i_clk);
    read_check("status_frame_err", 2'd1, 16'h0021);
    bus_write(2'd1, 16'h0020);
    read_check("status_frame_clr", 2'd1, 16'h0001);
    data_read_check("rx_after_frame_err");

    // RX interrupt: rises one cycle after rx_valid, falls one cycle after the clearing read
    bus_write(2'd2, 16'h0001);
    read_check("ctrl_rx_ie", 2'd2, 16'h0001);
    found = 1'b0;
    fork
      rx_frame(8'h5A);
      begin
        @(negedge i_clk);
        i_cs = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_addr = 2'd1;
        for (int i = 0; i < 200; i++) begin
          @(negedge i_clk);
          #1;
          if (o_wb_dat[2]) begin
            found = 1'b1;
            break;
          end
        end
      end
    join
    check_eq("rx_valid_seen", {31'd0, found}, 32'd1);
    check_eq("int_same_cycle", {31'd0, o_int}, 32'd0);
    @(negedge i_clk);
    #1 check_eq("int_after_valid", {31'd0, o_int}, 32'd1);
    i_wb_addr = 2'd0;
    #1 d = o_wb_dat;
    rx_model_read(e);
    check_eq("rx_int_data", {16'd0, d}, {16'd0, e});
    @(posedge i_clk);
    #1 i_cs = 1'b0; i_wb_cyc = 1'b0;
    @(negedge i_clk);
    check_eq("int_held_one_cycle", {31'd0, o_int}, 32'd1);
    @(negedge i_clk);
    check_eq("int_after_read", {31'd0, o_int}, 32'd0);

    // TX-idle interrupt, then reset in the middle of a frame
    bus_write(2'd2, 16'h0003);
    repeat (2) @(negedge i_clk);
    check_eq("int_tx_idle", {31'd0, o_int}, 32'd1);
    tx_exp_q.push_back(8'h3C);
    bus_write(2'd0, 16'h003C);
    repeat (15) @(negedge i_clk);
    @(posedge i_clk);
    #1 mon_en = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check_eq("reset_mid_tx", {31'd0, o_tx}, 32'd1);
    check_eq("reset_mid_int", {31'd0, o_int}, 32'd0);
    i_reset = 1'b0;
    tx_exp_q.delete();
    repeat (2) @(negedge i_clk);
    check_eq("tx_idle_after_reset", {31'd0, o_tx}, 32'd1);
    mon_en = 1'b1;
    read_check("status_after_reset", 2'd1, 16'h0001);
    read_check("ctrl_after_reset", 2'd2, 16'h0000);
    repeat (FRAME) @(negedge i_clk);
    check_eq("tx_quiet_after_reset", {31'd0, o_tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
